uart_rx_oversample: RTL
=======================

// Module: uart_rx_oversample
//
// PURPOSE
//  UART serial receiver (8N1 by default) driven by the 16x-oversample rx_en tick from the baud generator.
//  Synchronises the async rx line, validates the start bit at mid-bit and samples data/stop bits at bit centres.
//  Presents each byte on a valid/ready interface and flags framing errors and overruns.
//  Sits between the pad-level rx pin and the byte consumer (FIFO/command parser) in the uart directory.
//
// PARAMETERS
//  DATA_BITS   8   data bits per frame, LSB first (5..9)
//  OVERSAMPLE  16  rx_en ticks per bit period; must be even and >= 4
//
// PORTS
//  clk         in   1          system clock; single clock domain
//  rst         in   1          synchronous, active-high reset
//  rx_en       in   1          one-clk strobe at OVERSAMPLE x baud, from baud_generator
//  rx          in   1          async serial input, idle high
//  data_out    out  DATA_BITS  received byte; stable while data_valid=1
//  data_valid  out  1          byte available; held until accepted
//  data_ready  in   1          consumer accepts when data_valid & data_ready
//  frame_err   out  1          one-clk pulse: stop bit sampled 0
//  overrun     out  1          one-clk pulse: new byte lost, previous not yet accepted
//
// BEHAVIOUR
//  - Reset: state IDLE, counters 0, synchroniser FFs=1, data_out=0, data_valid=0, frame_err=0, overrun=0.
//  - rx passes a 2-FF synchroniser (rx_s); all decisions use rx_s. FSM/counters advance only on clk with rx_en=1.
//  - IDLE: rx_en & rx_s=0 -> START, tick_cnt=0.
//  - START: tick_cnt++ per tick; at tick_cnt==OVERSAMPLE/2-1 sample rx_s:
//      1 -> glitch, back to IDLE, no flags; 0 -> DATA, tick_cnt=0, bit_idx=0.
//  - DATA: tick_cnt++; at tick_cnt==OVERSAMPLE-1 sample rx_s into shift reg (LSB first), tick_cnt=0, bit_idx++;
//      after bit DATA_BITS-1 -> STOP.
//  - STOP: at tick_cnt==OVERSAMPLE-1 sample rx_s, then IDLE (mid-stop-bit; half-bit margin to detect next start).
//      1 -> byte complete; 0 -> frame_err=1 for one clk, byte discarded, data_valid unaffected.
//  - Byte complete, registered: next clk data_out<=byte, data_valid<=1 (latency 1 clk from stop sample).
//      If data_valid=1 and not accepted that same clk: new byte dropped, data_out keeps old, overrun=1 one clk.
//      If old byte accepted on the same clk: new byte loaded, data_valid stays 1, no overrun.
//  - Acceptance: data_valid & data_ready with no completion -> data_valid<=0 next clk; data_out holds value.
//  - Break (rx held 0): each frame ends frame_err; FSM restarts immediately since IDLE sees rx_s=0.
//  - rst mid-frame: abort immediately to reset values; partial byte discarded; next falling edge starts a new frame.
//  - rx_en ignored in counters while rst=1; flags never assert during reset.
//
// TESTING (50 MHz clk, baud_generator tick: rx_en every 27 clks, OVERSAMPLE=16)
//  1. Frame 0xA5, stop=1, data_ready=1 -> data_out=0xA5, data_valid high exactly 1 clk, no flags.
//  2. rx low for 4 rx_en ticks then high -> no valid/flags, FSM IDLE; following frame 0x3C received correctly.
//  3. Frame 0x55 with stop bit 0 -> frame_err 1-clk pulse, data_valid stays 0, data_out unchanged.
//  4. data_ready=0, frames 0x11 then 0x22 -> data_valid held, data_out=0x11, overrun pulse at 2nd; ready=1 -> valid drops.
//  5. rst pulsed during bit 3 of a frame -> all outputs reset values; next clean frame 0xF0 received correctly.
//  6. Back-to-back frames 0x00, 0xFF (no idle gap), data_ready=1 -> both bytes delivered in order, no flags.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//   UART receiver (8N1 by default) clocked by the 16x-oversample rx_en tick.
//   The async rx pin is brought in through a two-flop synchroniser. A start
//   bit is checked again at mid-bit to reject glitches. Data bits and the
//   stop bit are sampled at their bit centres. Each byte is offered on a
//   valid/ready handshake, and framing errors and overruns are flagged.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   rx_en       one-clk strobe at OVERSAMPLE x baud
//   rx          async serial input, idle high
//   data_out    received byte, stable while data_valid=1
//   data_valid  byte available, held until accepted
//   data_ready  consumer accepts when data_valid & data_ready
//   frame_err   one-clk pulse: stop bit sampled 0
//   overrun     one-clk pulse: completed byte dropped, previous not accepted
module uart_rx_oversample #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 rx_m, rx_s;
   logic                 byte_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         byte_done  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_m      <= rx;
         rx_s      <= rx_m;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         byte_done <= 1'b0;

         // Output stage, one clk behind the stop-bit sample. The shift
         // register is only written in DATA, so it is still intact here.
         if (byte_done) begin
            if (!data_valid || data_ready) begin
               data_out   <= shift;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end

         if (rx_en) begin
            case (state)
               IDLE: begin
                  if (!rx_s) begin
                     state    <= START;
                     tick_cnt <= '0;
                  end
               end
               START: begin
                  if (tick_cnt == TW'(OVERSAMPLE/2 - 1)) begin
                     // A start bit that is no longer low at mid-bit was a glitch.
                     if (rx_s) begin
                        state <= IDLE;
                     end else begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                     tick_cnt <= '0;
                     // LSB arrives first, so shift in from the top.
                     shift    <= {rx_s, shift[DATA_BITS-1:1]};
                     if (bit_idx == BW'(DATA_BITS - 1)) state <= STOP;
                     else bit_idx <= bit_idx + 1'b1;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               STOP: begin
                  // Return to IDLE at mid-stop-bit. This leaves half a bit of
                  // margin to catch a back-to-back start edge.
                  if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
                     tick_cnt <= '0;
                     state    <= IDLE;
                     if (rx_s) byte_done <= 1'b1;
                     else      frame_err <= 1'b1;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
